// File: rtl/cnt_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM state codes and direction values.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sequencer_if.sv
// Requester-side command bus of the counter sequencer: req/dir/len in, grant and done out.
interface counter_sequencer_if #(
    parameter int L = 8
);
    logic [1:0]   i_req;
    logic [1:0]   i_dir;
    logic [L-1:0] i_len0;
    logic [L-1:0] i_len1;
    logic [1:0]   o_gnt;
    logic [1:0]   o_done;

    modport master (output i_req, i_dir, i_len0, i_len1, input  o_gnt, o_done);
    modport slave  (input  i_req, i_dir, i_len0, i_len1, output o_gnt, o_done);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer register names the favoured requester
// and is loaded from i_ptr whenever i_upd strobes.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic ptr_q;
    logic ptr_d;

    assign ptr_d = i_upd ? i_ptr : ptr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end

    // NOTE: o_gnt gets a default before the conditional so no path leaves it unassigned (no latch).
    always_comb begin
        o_gnt = i_req;
        if (&i_req) o_gnt = ptr_q ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/counter_sequencer.sv
// Round-robin sequencer driving a shared mod-N up/down counter, with a shadow position.
// Optional run abort is compiled in with `define CNT_SEQ_ABORT_EN.
module counter_sequencer
    import cnt_seq_pkg::*;
#(
    parameter int N = 7,
    parameter int K = 3,
    parameter int L = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    counter_sequencer_if.slave  bus,
    input  logic                i_abort,
    output logic                o_cnt_en,
    output logic                o_cnt_up_down,
    output logic [K-1:0]        o_pos,
    output logic                o_busy
);

    state_t       state_q;
    logic         owner_q;
    logic         dir_q;
    logic [L-1:0] rem_q;
    logic [K-1:0] pos_q;
    logic [1:0]   done_q;

    logic [1:0]   arb_gnt;
    logic         accept;
    logic         req_owner;
    logic [L-1:0] req_len;
    logic         run_last;
    logic [K-1:0] pos_d;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (bus.i_req),
        .i_ptr   (~owner_q),
        .i_upd   (state_q == S_DONE),
        .o_gnt   (arb_gnt)
    );

    assign req_owner = arb_gnt[1];
    assign req_len   = req_owner ? bus.i_len1 : bus.i_len0;
    assign accept    = (state_q == S_IDLE) && |(bus.i_req & arb_gnt);

`ifdef CNT_SEQ_ABORT_EN
    assign run_last = (rem_q == L'(1)) || i_abort;
`else
    logic unused_abort;
    assign unused_abort = i_abort;
    assign run_last     = (rem_q == L'(1));
`endif

    // Same wrap rule as the driven counter: compare first, then step in K bits.
    always_comb begin
        if (dir_q == DIR_UP) pos_d = (pos_q == K'(N - 1)) ? '0 : pos_q + K'(1);
        else                 pos_d = (pos_q == '0) ? K'(N - 1) : pos_q - K'(1);
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            dir_q   <= DIR_DOWN;
            rem_q   <= '0;
            pos_q   <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        owner_q <= req_owner;
                        dir_q   <= bus.i_dir[req_owner];
                        rem_q   <= req_len;
                        if (req_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= {req_owner, ~req_owner};
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    pos_q <= pos_d;
                    rem_q <= rem_q - L'(1);
                    if (run_last) begin
                        state_q <= S_DONE;
                        done_q  <= {owner_q, ~owner_q};
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so reset drops the enable asynchronously.
    assign o_cnt_en      = (state_q == S_RUN);
    assign o_cnt_up_down = (state_q == S_RUN) && dir_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_pos         = pos_q;
    assign bus.o_gnt     = (state_q == S_IDLE) ? arb_gnt : 2'b00;
    assign bus.o_done    = done_q;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Sequencer and arbiter for the shared mod-N up/down counter. Two requesters submit run commands (a direction and a step count) over a req/gnt handshake. The block grants them round-robin, drives the counter's enable and up/down inputs for exactly the commanded number of cycles, and pulses done back to the owner. It keeps a shadow copy of the counter position so clients can read where a run ends without tapping the counter itself.

## Interface
- N, 7, modulus of the driven counter; counts 0..N-1
- K, 3, counter/position width; requires 2^K >= N
- L, 8, step-length field width
- i_clk  in  1  clock, shared with the driven counter
- i_rst_n  in  1  asynchronous, active-low reset; the driven counter receives its inverse
- i_req  in  2  per-requester command valid
- i_dir  in  2  per-requester direction; 1 = up, 0 = down
- i_len0  in  L  step count, requester 0
- i_len1  in  L  step count, requester 1
- i_abort  in  1  terminate the current run (see Configuration)
- o_gnt  out  2  one-hot grant; a command is accepted in the cycle where i_req[r] & o_gnt[r]
- o_cnt_en  out  1  to the counter's i_en
- o_cnt_up_down  out  1  to the counter's i_up_down
- o_pos  out  K  shadow position, equal to the counter's o_Q
- o_busy  out  1  high in any state other than IDLE
- o_done  out  2  one-cycle pulse to the owner when its run ends

## Operation
- States:
  - IDLE: o_gnt = arbiter result when any i_req is set. On acceptance, latch owner, dir and len.
    - len == 0 goes to DONE.
    - Otherwise go to RUN with rem = len.
  - RUN: o_cnt_en = 1 and o_cnt_up_down = latched dir. rem decrements each cycle; when rem == 1, go to DONE.
  - DONE: o_done[owner] = 1, arbiter pointer updates, go to IDLE.
- o_gnt is zero outside IDLE. Requesters hold i_req, i_dir and i_len stable until granted.
- Arbitration is round-robin over 2 requesters.
  - After reset the pointer favours requester 0.
  - After a DONE for owner r, the pointer favours 1-r.
  - A lone requester is granted regardless of the pointer.
- Shadow position updates on each RUN cycle with the counter's rule:
  - up: N-1 wraps to 0, else +1.
  - down: 0 wraps to N-1, else -1.
  - Arithmetic is K bits, with the compare done before the increment or decrement.
- o_cnt_en, o_cnt_up_down, o_gnt and o_busy are decoded from the state register. o_done is registered.
- Reset values: state IDLE, o_pos 0, rem 0, owner 0, pointer 0, all outputs 0.

## Timing
- Accept in cycle t. Cycles t+1..t+len are RUN, with o_cnt_en high for exactly len cycles. Cycle t+len+1 is DONE. The earliest next grant is t+len+2.
- len == 0: DONE at t+1 and no enable pulse.
- Latency from accept to done pulse is len+1 cycles. The back-to-back command period is len+2.
- o_pos and the counter update on the same edge, so they are equal in every cycle.
- Asserting i_rst_n low mid-run forces IDLE and drives o_cnt_en low immediately (asynchronously). o_pos resets to 0, in step with the counter's reset.
- i_req changing while the block is busy has no effect until IDLE.

## Configuration
- CNT_SEQ_ABORT_EN defined:
  - i_abort high in a RUN cycle ends the run. That cycle's enable still counts, the next state is DONE with a normal o_done pulse, and the remaining steps are discarded.
  - i_abort is ignored outside RUN.
- CNT_SEQ_ABORT_EN undefined: the i_abort port remains but is ignored, and every run completes its full length.

## Structure
- Shared package cnt_seq_pkg holds:
  - the state encoding constants S_IDLE, S_RUN and S_DONE
  - DIR_UP = 1 and DIR_DOWN = 0
- Sub-module rr_arb2 is the 2-way round-robin arbiter. Its inputs are req[1:0], pointer and an update strobe; its output is the one-hot grant.
- The counter itself is not instantiated here. The integration level connects o_cnt_en and o_cnt_up_down to it, and feeds it the inverse of i_rst_n.

## Test plan
Defaults throughout are N=7, K=3, L=8.
- Up run:
  - Stimulus: after reset, i_req=01, i_dir[0]=1, i_len0=3.
  - Response: gnt=01 at t, o_cnt_en high for t+1..t+3, o_pos goes 1,2,3, o_done=01 at t+4, o_busy low at t+5.
- Down wrap:
  - Stimulus: o_pos=0, requester 1 with dir 0 and len 2.
  - Response: o_pos goes 6 then 5, o_cnt_up_down=0 throughout, o_done=10.
- Up wrap:
  - Stimulus: o_pos=5, up run with len 3.
  - Response: o_pos goes 6,0,1 and stays in lockstep with the counter's o_Q.
- Round-robin:
  - Stimulus: both requesters hold requests after reset, each with len 1.
  - Response: grant order is 0,1,0,1, and grants are spaced 3 cycles apart.
- Zero length:
  - Stimulus: len 0.
  - Response: no o_cnt_en pulse, o_done at t+1, o_pos unchanged.
- Abort and reset:
  - Abort stimulus: with CNT_SEQ_ABORT_EN, len 10, i_abort asserted in the third RUN cycle.
  - Abort response: exactly 3 enable pulses, then o_done.
  - Without CNT_SEQ_ABORT_EN: the same run gives 10 enable pulses.
  - Reset mid-run response: o_cnt_en drops immediately and o_pos=0.
